llsc_link_controller: RTL
=========================

Name: llsc_link_controller

Overview:
Sequences the data-cache port for every memory op leaving EX, and owns the LL/SC link register (link_valid, link_addr, expiry timer).
Decides SC success and suppresses the cache write on SC failure.
Produces the SC result word for write-back and the mem-stage done/stall signal.
Sits between EX-stage glue (llsc/d-cache inputs) and the d-cache; MEM-stage glue consumes o_done and o_sc_result.

Parameters:
ADDR_WIDTH, 26, byte address width of cache requests
DATA_WIDTH, 32, register/data word width
LINK_TIMEOUT, 1024, cycles a link stays valid without SC before forced expiry (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  memory op present at EX/MEM boundary
i_is_ll  in  1  op is LL (read)
i_is_sc  in  1  op is SC (write)
i_is_sw  in  1  op is plain SW
i_addr  in  ADDR_WIDTH  effective byte address
i_data  in  DATA_WIDTH  store data
i_advance  in  1  MEM stage register loads next instruction this cycle
i_ext_clear  in  1  flush/eret: drop link
o_cache_valid  out  1  cache request
o_cache_write  out  1  1=WRITE, 0=READ (mem_action)
o_cache_addr  out  ADDR_WIDTH  request address
o_cache_data  out  DATA_WIDTH  write data
i_cache_done  in  1  cache output valid
o_done  out  1  MEM op complete; 0 stalls pipeline
o_sc_result  out  DATA_WIDTH  {31'b0,success}, meaningful when o_sc_valid
o_sc_valid  out  1  o_sc_result valid (SC completed)
o_link_valid  out  1  link state (debug/verification)
o_link_addr  out  ADDR_WIDTH  linked address

Behaviour:
- Reset (async, rst_n=0): state IDLE; link_valid=0; link_addr=0; timer=0; o_sc_result=0; o_sc_valid=0; o_cache_valid=0; o_done=1.
- Inputs i_* are held stable by upstream while o_done=0.
- Address match compares word addresses only: addr[ADDR_WIDTH-1:2].
- FSM states: IDLE, LL_BUSY, SC_BUSY, PASS_BUSY, SC_FAIL, COMPLETE.
- IDLE, i_valid=0: o_done=1, no request.
- IDLE, i_valid=1:
  - LL -> LL_BUSY.
  - SC with link_valid and match -> SC_BUSY.
  - SC otherwise -> SC_FAIL.
  - other (load/SW) -> PASS_BUSY.
  - o_done=0 in the accept cycle.
- Cache request: o_cache_valid=1 in LL_BUSY, SC_BUSY and PASS_BUSY, starting the cycle after accept (registered request).
  - addr/data taken from i_*.
  - write=1 for SC/SW.
- LL_BUSY/SC_BUSY/PASS_BUSY + i_cache_done: o_done=1 combinationally that cycle, then -> COMPLETE.
- LL completion: link_valid<=1, link_addr<=i_addr, timer<=0.
- SC_BUSY completion: o_sc_result<=1, o_sc_valid<=1, link_valid<=0.
- SC_FAIL: no cache request ever; one cycle with o_done=0; then o_sc_result<=0, o_sc_valid<=1 -> COMPLETE. Total latency 2 cycles.
- PASS_BUSY write completion with word match to link_addr: link_valid<=0.
- COMPLETE: o_done=1, SC result held; i_advance -> IDLE and clear o_sc_valid. No re-issue while stalled downstream.
- Timer:
  - Increments each cycle while link_valid.
  - At LINK_TIMEOUT-1, link_valid<=0 and timer<=0.
  - Width $clog2(LINK_TIMEOUT).
- Priority, same cycle: i_ext_clear > LL set > SW-match clear / timeout.
  - i_ext_clear during LL_BUSY completion leaves link_valid=0.
  - i_ext_clear while in SC_BUSY does not abort the issued write; success is still reported.
- i_advance outside COMPLETE is ignored.
- Reset mid-operation: request dropped immediately, link lost.

Decomposition:
- mips_core_pkg: llsc_state_e enum (6 states), LLSC_SUCCESS/LLSC_FAIL DATA_WIDTH constants; reuse existing mem_action_t for o_cache_write.
- Sub-module llsc_link_reg: link_valid/link_addr/timer with set, clear, match and expiry logic; controller FSM instantiates it.

Test Plan:
- LL 0x100, cache done after 3 cycles, i_advance; then SC 0x104 (same word 0x100>>2? no, different word) -> SC_FAIL, no cache request, o_sc_result=0, o_done low 1 cycle.
- LL 0x200 then SC 0x200, cache done 2 cycles -> write issued, o_sc_result=1, o_link_valid=0 after completion.
- LL 0x300, SW 0x302 completes, SC 0x300 -> link cleared by SW, SC fails with result 0, no write.
- LL 0x400, idle LINK_TIMEOUT=8 cycles -> o_link_valid falls at cycle 8; subsequent SC 0x400 fails.
- LL completing same cycle as i_ext_clear -> o_link_valid stays 0; SC 0x500 fails.
- SC success with i_advance held low 5 cycles -> exactly one cache write, o_done=1 and o_sc_result=1 held until i_advance; rst_n pulse mid-LL_BUSY -> o_cache_valid=0, link_valid=0 at once.

Source files
------------

// File: rtl/llsc_link_controller_pkg.sv
// Shared types and constants for the LL/SC link controller and its link register.
package llsc_link_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LL_BUSY,
    SC_BUSY,
    PASS_BUSY,
    SC_FAIL,
    COMPLETE
  } llsc_state_e;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_action_t;

  // SC write-back words; the controller zero-extends them to its data width.
  localparam logic [31:0] LLSC_SUCCESS = 32'd1;
  localparam logic [31:0] LLSC_FAIL    = 32'd0;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: valid flag, linked byte address and expiry timer.
// Priority of same-cycle updates: ext_clear > set > kill / timeout.
module llsc_link_reg #(
  parameter int ADDR_WIDTH   = 26,
  parameter int LINK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_clear,
  input  logic                  set,
  input  logic                  kill,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic                  link_valid,
  output logic [ADDR_WIDTH-1:0] link_addr,
  output logic                  match
);

  localparam int TW = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_TIMEOUT - 1);

  logic [TW-1:0] timer;
  logic          expire;

  assign expire = link_valid && (timer == TIMER_LAST);

  // Reservations are word granular; the byte offset never takes part.
  assign match = (link_addr[ADDR_WIDTH-1:2] == cmp_addr[ADDR_WIDTH-1:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
      timer      <= '0;
    end else begin
      if (set) begin
        link_addr <= set_addr;
      end
      if (ext_clear) begin
        link_valid <= 1'b0;
        timer      <= '0;
      end else if (set) begin
        link_valid <= 1'b1;
        timer      <= '0;
      end else if (kill || expire) begin
        link_valid <= 1'b0;
        timer      <= '0;
      end else if (link_valid) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/llsc_link_controller.sv
// Sequences the d-cache port for each memory op leaving EX and decides SC success
// against the link register; produces the MEM done/stall and SC result word.
module llsc_link_controller
  import llsc_link_controller_pkg::*;
#(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int LINK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic                  i_is_ll,
  input  logic                  i_is_sc,
  input  logic                  i_is_sw,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_advance,
  input  logic                  i_ext_clear,
  output logic                  o_cache_valid,
  output logic                  o_cache_write,
  output logic [ADDR_WIDTH-1:0] o_cache_addr,
  output logic [DATA_WIDTH-1:0] o_cache_data,
  input  logic                  i_cache_done,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_sc_result,
  output logic                  o_sc_valid,
  output logic                  o_link_valid,
  output logic [ADDR_WIDTH-1:0] o_link_addr
);

  localparam logic [DATA_WIDTH-1:0] SC_WORD_OK   = DATA_WIDTH'(LLSC_SUCCESS);
  localparam logic [DATA_WIDTH-1:0] SC_WORD_FAIL = DATA_WIDTH'(LLSC_FAIL);

  llsc_state_e           state;
  llsc_state_e           state_next;
  mem_action_t           req_action;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  accept;
  logic                  link_valid;
  logic [ADDR_WIDTH-1:0] link_addr;
  logic                  link_match;
  logic                  link_set;
  logic                  link_kill;
  logic                  sc_hit;

  assign accept = (state == IDLE) && i_valid;
  assign sc_hit = link_valid && link_match;

  // Link updates happen on the cache handshake; a plain store only breaks a
  // reservation on the same word.
  assign link_set  = (state == LL_BUSY) && i_cache_done;
  assign link_kill = i_cache_done &&
                     ((state == SC_BUSY) ||
                      ((state == PASS_BUSY) && (req_action == MEM_WRITE) && link_match));

  llsc_link_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LINK_TIMEOUT(LINK_TIMEOUT)
  ) u_link_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_clear (i_ext_clear),
    .set       (link_set),
    .kill      (link_kill),
    .set_addr  (req_addr),
    .cmp_addr  (i_addr),
    .link_valid(link_valid),
    .link_addr (link_addr),
    .match     (link_match)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_is_ll)      state_next = LL_BUSY;
          else if (i_is_sc) state_next = sc_hit ? SC_BUSY : SC_FAIL;
          else              state_next = PASS_BUSY;
        end
      end
      LL_BUSY, SC_BUSY, PASS_BUSY: begin
        if (i_cache_done) state_next = COMPLETE;
      end
      SC_FAIL:  state_next = COMPLETE;
      COMPLETE: begin
        if (i_advance) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    o_done        = 1'b1;
    o_cache_valid = 1'b0;
    unique case (state)
      IDLE:                        o_done = !i_valid;
      LL_BUSY, SC_BUSY, PASS_BUSY: begin
        o_cache_valid = 1'b1;
        o_done        = i_cache_done;
      end
      SC_FAIL:                     o_done = 1'b0;
      default:                     o_done = 1'b1;
    endcase
  end

  // NOTE: the request datapath is reset as well, so the cache port never
  // presents X addresses or data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_action <= MEM_READ;
      req_addr   <= '0;
      req_data   <= '0;
    end else if (accept) begin
      req_action <= (!i_is_ll && (i_is_sc || i_is_sw)) ? MEM_WRITE : MEM_READ;
      req_addr   <= i_addr;
      req_data   <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sc_result <= '0;
      o_sc_valid  <= 1'b0;
    end else if ((state == SC_BUSY) && i_cache_done) begin
      o_sc_result <= SC_WORD_OK;
      o_sc_valid  <= 1'b1;
    end else if (state == SC_FAIL) begin
      o_sc_result <= SC_WORD_FAIL;
      o_sc_valid  <= 1'b1;
    end else if ((state == COMPLETE) && i_advance) begin
      o_sc_valid <= 1'b0;
    end
  end

  assign o_cache_write = (req_action == MEM_WRITE);
  assign o_cache_addr  = req_addr;
  assign o_cache_data  = req_data;
  assign o_link_valid  = link_valid;
  assign o_link_addr   = link_addr;

endmodule
